// File: rtl/fpu_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_arbiter_pkg : opcodes, FSM encoding and constants for fpu_arbiter     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fpu_arbiter_pkg;

  localparam logic [3:0]  OP_ADD = 4'b0000;
  localparam logic [3:0]  OP_SUB = 4'b0001;
  localparam logic [3:0]  OP_MUL = 4'b0010;
  localparam logic [3:0]  OP_DIV = 4'b0011;

  localparam logic [31:0] UNSUP_RESULT = 32'h000B00B5;
  localparam logic [31:0] QNAN         = 32'h7FC00000;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_supported(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_top : combinational single-precision add/sub/mul, round-to-nearest-   |
// | even, subnormals flushed to zero. Rev 1.0                                 |
// +--------------------------------------------------------------------------+
module fpu_top
  import fpu_arbiter_pkg::*;
(
  input  logic [31:0] num1_i,
  input  logic [31:0] num2_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o
);

  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Rounding carry ripples from fraction into exponent, so overflow to inf falls out naturally.
  function automatic logic [31:0] pack_round(input logic s, input logic signed [10:0] e,
                                             input logic [22:0] frac, input logic g,
                                             input logic st);
    logic [30:0] mag;
    if (e >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 11'sd0)   return {s, 31'd0};
    mag = {e[7:0], frac} + {30'd0, g & (st | frac[0])};
    return {s, mag};
  endfunction

  logic        sa, sb, sb_eff;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign {sa, ea, fa} = num1_i;
  assign {sb, eb, fb} = num2_i;
  assign sb_eff = sb ^ op_i[0];
  assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
  assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
  assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
  assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
  assign zero_a = (ea == 8'd0);
  assign zero_b = (eb == 8'd0);

  logic               a_big, sx, sy;
  logic [7:0]         ex, ey, d;
  logic [22:0]        fx, fy;
  logic [23:0]        mx, my;
  logic [26:0]        my_ext, y_sh, norm;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic signed [10:0] e_add;
  logic [31:0]        add_res;

  always_comb begin : add_path
    a_big  = num1_i[30:0] >= num2_i[30:0];
    sx     = a_big ? sa     : sb_eff;
    sy     = a_big ? sb_eff : sa;
    ex     = a_big ? ea : eb;
    ey     = a_big ? eb : ea;
    fx     = a_big ? fa : fb;
    fy     = a_big ? fb : fa;
    mx     = (ex == 8'd0) ? 24'd0 : {1'b1, fx};
    my     = (ey == 8'd0) ? 24'd0 : {1'b1, fy};
    d      = ex - ey;
    my_ext = {my, 3'b000};
    if (d >= 8'd27) y_sh = {26'd0, |my};
    else            y_sh = (my_ext >> d) | {26'd0, |(my_ext & ((27'd1 << d) - 27'd1))};
    if (sx == sy) sum = {1'b0, mx, 3'b000} + {1'b0, y_sh};
    else          sum = {1'b0, mx, 3'b000} - {1'b0, y_sh};
    lz = clz27(sum[26:0]);
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      e_add = $signed({3'b000, ex}) + 11'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      e_add = $signed({3'b000, ex}) - $signed({6'd0, lz});
    end
    if (nan_a || nan_b)                       add_res = QNAN;
    else if (inf_a && inf_b && (sa != sb_eff)) add_res = QNAN;
    else if (inf_a)                           add_res = {sa, 8'hFF, 23'd0};
    else if (inf_b)                           add_res = {sb_eff, 8'hFF, 23'd0};
    else if (!norm[26])                       add_res = 32'd0;
    else add_res = pack_round(sx, e_add, norm[25:3], norm[2], |norm[1:0]);
  end

  logic               s_mul, m_g, m_st;
  logic [47:0]        prod;
  logic [22:0]        m_frac;
  logic signed [10:0] e_mul;
  logic [31:0]        mul_res;

  always_comb begin : mul_path
    s_mul = sa ^ sb;
    prod  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    e_mul = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
            + (prod[47] ? 11'sd1 : 11'sd0);
    if (prod[47]) begin
      m_frac = prod[46:24];
      m_g    = prod[23];
      m_st   = |prod[22:0];
    end else begin
      m_frac = prod[45:23];
      m_g    = prod[22];
      m_st   = |prod[21:0];
    end
    if (nan_a || nan_b)          mul_res = QNAN;
    else if (inf_a || inf_b)     mul_res = (zero_a || zero_b) ? QNAN : {s_mul, 8'hFF, 23'd0};
    else if (zero_a || zero_b)   mul_res = {s_mul, 31'd0};
    else                         mul_res = pack_round(s_mul, e_mul, m_frac, m_g, m_st);
  end

  assign result_o = (op_i == OP_MUL) ? mul_res : add_res;

endmodule
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_arbiter : two-requester arbiter in front of one shared fpu_top.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_num1,
  input  logic [31:0] a_num2,
  input  logic [3:0]  a_op,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_num1,
  input  logic [31:0] b_num2,
  input  logic [3:0]  b_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic        busy
);

  state_e      state_q;
  logic [31:0] num1_q, num2_q;
  logic [3:0]  op_q;
  logic        id_q;
  logic        last_grant_q;
  logic [31:0] rsp_result_q;
  logic        rsp_err_q, rsp_id_q, rsp_valid_q, busy_q;

  logic        w_idle, w_pick_b, w_op_err;
  logic [31:0] w_fpu_result;

  // B wins only when alone, or in round-robin mode when A was served last.
  assign w_pick_b = b_valid & (~a_valid | (RR_EN && (last_grant_q == GRANT_A)));
  assign w_idle   = rst_n && (state_q == ST_IDLE);
  assign a_ready  = w_idle & a_valid & ~w_pick_b;
  assign b_ready  = w_idle & w_pick_b;
  assign w_op_err = !op_supported(op_q);

  fpu_top u_fpu (
    .num1_i   (num1_q),
    .num2_i   (num2_q),
    .op_i     (op_q),
    .result_o (w_fpu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num1_q       <= 32'd0;
      num2_q       <= 32'd0;
      op_q         <= 4'd0;
      id_q         <= 1'b0;
      last_grant_q <= GRANT_B;
      rsp_result_q <= 32'd0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (a_valid || b_valid) begin
            num1_q       <= w_pick_b ? b_num1 : a_num1;
            num2_q       <= w_pick_b ? b_num2 : a_num2;
            op_q         <= w_pick_b ? b_op   : a_op;
            id_q         <= w_pick_b;
            last_grant_q <= w_pick_b;
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= w_op_err ? UNSUP_RESULT : w_fpu_result;
          rsp_err_q    <= w_op_err;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpu_arbiter : scoreboard bench, round-robin and fixed-priority DUTs    |
// | driven from shared stimulus. Rev 1.0                                      |
// +--------------------------------------------------------------------------+
module tb_fpu_arbiter;
  import fpu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, rsp_ready;
  logic [31:0] a_num1, a_num2, b_num1, b_num2;
  logic [3:0]  a_op, b_op;

  logic        a_ready, b_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_result;
  logic        f_a_ready, f_b_ready, f_rsp_valid, f_rsp_id, f_rsp_err, f_busy;
  logic [31:0] f_rsp_result;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] res;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_num1(a_num1), .a_num2(a_num2), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_num1(b_num1), .b_num2(b_num2), .b_op(b_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  fpu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(f_a_ready), .a_num1(a_num1), .a_num2(a_num2), .a_op(a_op),
    .b_valid(b_valid), .b_ready(f_b_ready), .b_num1(b_num1), .b_num2(b_num2), .b_op(b_op),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(f_rsp_result),
    .rsp_id(f_rsp_id), .rsp_err(f_rsp_err), .busy(f_busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitors: pop and compare whenever a response is consumed.
  always @(negedge clk) begin : mon_rr
    exp_t e;
    if (rst_n) begin
      check("rr_ready_excl", 32'(a_ready & b_ready), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (q_rr.size() == 0) check("rr_unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = q_rr.pop_front();
          check("rr_rsp_result", rsp_result, e.res);
          check("rr_rsp_id", 32'(rsp_id), 32'(e.id));
          check("rr_rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_fp
    exp_t e;
    if (rst_n) begin
      check("fp_ready_excl", 32'(f_a_ready & f_b_ready), 32'd0);
      if (f_rsp_valid && rsp_ready) begin
        if (q_fp.size() == 0) check("fp_unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = q_fp.pop_front();
          check("fp_rsp_result", f_rsp_result, e.res);
          check("fp_rsp_id", 32'(f_rsp_id), 32'(e.id));
          check("fp_rsp_err", 32'(f_rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic scramble();
    a_num1 = 32'hDEADBEEF; a_num2 = 32'hCAFEF00D; a_op = 4'hF;
    b_num1 = 32'h12345678; b_num2 = 32'h87654321; b_op = 4'hE;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || f_busy) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_timeout", 32'(busy | f_busy), 32'd0);
  endtask

  task automatic drive(input bit who, input logic [31:0] n1, input logic [31:0] n2,
                       input logic [3:0] op);
    if (who) begin b_valid = 1'b1; b_num1 = n1; b_num2 = n2; b_op = op; end
    else     begin a_valid = 1'b1; a_num1 = n1; a_num2 = n2; a_op = op; end
  endtask

  // Returns at posedge+1 of the capturing edge with valids dropped.
  task automatic wait_grant(input bit who);
    int k = 0;
    bit got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      got = who ? b_ready : a_ready;
      @(posedge clk); #1;
      k++;
    end
    check("grant", 32'(got), 32'd1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    scramble();
  endtask

  task automatic issue(input bit who, input logic [31:0] n1, input logic [31:0] n2,
                       input logic [3:0] op, input logic [31:0] res, input bit err,
                       input bit lat);
    exp_t e;
    e = {who, err, res};
    q_rr.push_back(e);
    q_fp.push_back(e);
    drive(who, n1, n2, op);
    wait_grant(who);
    if (lat) begin
      check("lat_exec_rsp_valid", 32'(rsp_valid), 32'd0);
      check("lat_exec_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("lat_resp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    wait_idle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    int k;
    rst_n = 1'b0; rsp_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    scramble();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous contention straight out of reset.
    for (int i = 0; i < 4; i++) begin
      q_rr.push_back((i % 2 == 0) ? {1'b0, 1'b0, 32'h40400000} : {1'b1, 1'b0, 32'h40C00000});
      q_fp.push_back({1'b0, 1'b0, 32'h40400000});
    end
    drive(1'b0, 32'h3F800000, 32'h40000000, OP_ADD);
    drive(1'b1, 32'h40400000, 32'h40000000, OP_MUL);
    cnt = 0; k = 0;
    while (cnt < 4 && k < 40) begin
      @(negedge clk);
      if (a_ready || b_ready) cnt++;
      @(posedge clk); #1;
      k++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("contention_grants", 32'(cnt), 32'd4);
    wait_idle();

    issue(1'b0, 32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0, 1'b1);
    issue(1'b1, 32'h40400000, 32'h40000000, OP_MUL, 32'h40C00000, 1'b0, 1'b0);
    issue(1'b1, 32'h40000000, 32'h3F800000, OP_SUB, 32'h3F800000, 1'b0, 1'b0);
    issue(1'b0, 32'h3F800000, 32'h40000000, OP_DIV, 32'h000B00B5, 1'b1, 1'b0);
    issue(1'b1, 32'h3F800000, 32'h40000000, 4'b1111, 32'h000B00B5, 1'b1, 1'b0);
    issue(1'b0, 32'h3F000000, 32'hBE800000, OP_ADD, 32'h3E800000, 1'b0, 1'b0);
    issue(1'b0, 32'h3F800000, 32'h33C00000, OP_ADD, 32'h3F800001, 1'b0, 1'b0);

    // Back-pressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    q_rr.push_back({1'b1, 1'b0, 32'h40C00000});
    q_fp.push_back({1'b1, 1'b0, 32'h40C00000});
    drive(1'b1, 32'h40400000, 32'h40000000, OP_MUL);
    wait_grant(1'b1);
    k = 0;
    while (!rsp_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_result", rsp_result, 32'h40C00000);
      check("hold_rsp_id", 32'(rsp_id), 32'd1);
      check("hold_a_ready", 32'(a_ready), 32'd0);
      check("hold_b_ready", 32'(b_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_busy", 32'(busy), 32'd0);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset asserted while an operation is in EXEC.
    drive(1'b0, 32'h3F800000, 32'h40000000, OP_ADD);
    wait_grant(1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fp_busy", 32'(f_busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_result", rsp_result, 32'd0);
    check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("mid_rst_a_ready", 32'(a_ready), 32'd0);
    check("mid_rst_b_ready", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(1'b1, 32'h40000000, 32'h3F800000, OP_SUB, 32'h3F800000, 1'b0, 1'b0);
    issue(1'b0, 32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0, 1'b1);

    k = 0;
    while ((q_rr.size() != 0 || q_fp.size() != 0) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("rr_queue_drained", 32'(q_rr.size()), 32'd0);
    check("fp_queue_drained", 32'(q_fp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
